// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned MIN_DATA_LEN = 5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three centred samples and majority vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxs,
  input  logic               start,
  input  logic               active,
  input  logic               clear,
  input  logic [PRESC_W-1:0] prescale,
  output logic               samp_last,
  output logic               bit_end,
  output logic               bit_val
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESC_W-1:0] half;
  logic [1:0]         samp_q, samp_d;

  assign half      = prescale >> 1;
  assign samp_last = active && (edge_cnt_q == half + ONE);
  assign bit_end   = active && (edge_cnt_q == prescale - ONE);
  // Third sample is the live line value, so the vote is ready at half+1.
  assign bit_val   = maj3(samp_q[0], samp_q[1], rxs);

  always_comb begin
    samp_d = samp_q;
    if (active && (edge_cnt_q == half - ONE)) samp_d[0] = rxs;
    if (active && (edge_cnt_q == half))       samp_d[1] = rxs;

    if (start)                 edge_cnt_d = ONE;
    else if (active && !clear) edge_cnt_d = bit_end ? '0 : edge_cnt_q + ONE;
    else                       edge_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      samp_q     <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx_gen.sv
// Runtime-configurable UART receiver: frame FSM, shifter, parity and output register.
module uart_rx_gen
  import uart_rx_pkg::*;
#(
  parameter int unsigned MAX_DATA_W = 9,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic [MAX_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  par_err,
  output logic                  frm_err,
  output logic                  brk_det,
  output logic                  ovr_err
);

  localparam logic [3:0] MIN_LEN = 4'(MIN_DATA_LEN);
  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_W);

  logic [1:0]            sync_q, sync_d;
  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [3:0]            len_q, len_d, len_clamped;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [MAX_DATA_W-1:0] shreg_q, shreg_d;
  logic                  par_acc_q, par_acc_d, par_bad_q, par_bad_d;
  logic                  frm_q, frm_d, brk_q, brk_d;
  logic [MAX_DATA_W-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d, brk_det_q, brk_det_d, ovr_q, ovr_d;

  logic rxs, start, done, glitch, samp_last, bit_end, bit_val;

  assign rxs   = sync_q[1];
  assign start = (state_q == IDLE) && !rxs;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rxs       (rxs),
    .start     (start),
    .active    (state_q != IDLE),
    .clear     (done | glitch),
    .prescale  (presc_q),
    .samp_last (samp_last),
    .bit_end   (bit_end),
    .bit_val   (bit_val)
  );

  always_comb begin
    if (data_len < MIN_LEN)      len_clamped = MIN_LEN;
    else if (data_len > MAX_LEN) len_clamped = MAX_LEN;
    else                         len_clamped = data_len;
  end

  always_comb begin
    sync_d      = {sync_q[0], rx_in};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    presc_d     = presc_q;
    len_d       = len_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    stop2_d     = stop2_q;
    shreg_d     = shreg_q;
    par_acc_d   = par_acc_q;
    par_bad_d   = par_bad_q;
    frm_d       = frm_q;
    brk_d       = brk_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    brk_det_d   = brk_det_q;
    ovr_d       = 1'b0;
    done        = 1'b0;
    glitch      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          bit_cnt_d = '0;
          presc_d   = prescale;
          len_d     = len_clamped;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          stop2_d   = stop2;
          shreg_d   = '0;
          par_acc_d = 1'b0;
          par_bad_d = 1'b0;
          frm_d     = 1'b0;
          brk_d     = 1'b1;
        end
      end
      START: begin
        if (samp_last && bit_val) begin
          glitch  = 1'b1;
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (samp_last) begin
          for (int unsigned i = 0; i < MAX_DATA_W; i++)
            if (bit_cnt_q == 4'(i)) shreg_d[i] = bit_val;
          par_acc_d = par_acc_q ^ bit_val;
          brk_d     = brk_q & ~bit_val;
        end
        if (bit_end) begin
          if (bit_cnt_q == len_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (samp_last) begin
          par_bad_d = bit_val ^ par_acc_q ^ par_typ_q;
          brk_d     = brk_q & ~bit_val;
        end
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (samp_last) begin
          frm_d = frm_q | ~bit_val;
          brk_d = brk_q & ~bit_val;
          if (!stop2_q || (bit_cnt_q == 4'd1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
        if (bit_end && !done) bit_cnt_d = 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (done && (!out_valid_q || out_ready)) begin
      out_data_d  = shreg_q;
      par_err_d   = par_bad_q;
      frm_err_d   = frm_d;
      brk_det_d   = brk_d;
      out_valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      presc_q     <= '0;
      len_q       <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      shreg_q     <= '0;
      par_acc_q   <= 1'b0;
      par_bad_q   <= 1'b0;
      frm_q       <= 1'b0;
      brk_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      brk_det_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      presc_q     <= presc_d;
      len_q       <= len_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      stop2_q     <= stop2_d;
      shreg_q     <= shreg_d;
      par_acc_q   <= par_acc_d;
      par_bad_q   <= par_bad_d;
      frm_q       <= frm_d;
      brk_q       <= brk_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      brk_det_q   <= brk_det_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign par_err   = par_err_q;
  assign frm_err   = frm_err_q;
  assign brk_det   = brk_det_q;
  assign ovr_err   = ovr_q;

endmodule
